// File: rtl/unstripe_ctrl.sv
// unstripe_ctrl: rebuilds one word stream from two striped lanes, each buffered
// in a 2-deep FIFO and drained alternately starting with lane 0.
module unstripe_ctrl #(
  parameter int STALL_MAX = 15,
  parameter int W = 32
) (
  input  logic         clk_2f,
  input  logic         reset_L,
  input  logic         enable,
  input  logic         valid_0,
  input  logic         valid_1,
  input  logic [W-1:0] lane_0,
  input  logic [W-1:0] lane_1,
  output logic [W-1:0] data_out,
  output logic         valid_out,
  output logic         lane_sel,
  output logic         error,
  output logic [2:0]   state,
  output logic [15:0]  word_cnt
);
  localparam int SW = $clog2(STALL_MAX + 1);
  typedef enum logic [2:0] {IDLE = 3'd0, SYNC = 3'd1, RUN_L0 = 3'd2, RUN_L1 = 3'd3, ERR = 3'd4} state_t;
  state_t         r_state, w_next;
  logic [SW-1:0]  r_stall;
  logic [W-1:0]   r_data;
  logic           r_valid, r_lane_sel;
  logic [15:0]    r_word_cnt;
  logic [W-1:0]   w_lane [2];
  logic [W-1:0]   w_head [2];
  logic [1:0]     w_cnt [2];
  logic [1:0]     w_push, w_pop_raw, w_pop, w_full;
  logic           w_run, w_ovf, w_timeout, w_err, w_keep;
  assign w_lane[0] = lane_0;
  assign w_lane[1] = lane_1;
  assign w_run     = (r_state == RUN_L0) || (r_state == RUN_L1);
  assign w_push    = (enable && (r_state == SYNC || w_run)) ? {valid_1, valid_0} : 2'b00;
  assign w_pop_raw = {r_state == RUN_L1 && w_cnt[1] != 2'd0, r_state == RUN_L0 && w_cnt[0] != 2'd0};
  assign w_full    = {w_cnt[1] == 2'd2, w_cnt[0] == 2'd2};
  // a full FIFO may accept a push only when the same edge drains its head
  assign w_ovf     = |(w_push & w_full & ~w_pop_raw);
  assign w_timeout = w_run && !(|w_pop_raw) && r_stall == SW'(STALL_MAX - 1);
  assign w_err     = w_ovf || w_timeout;
  assign w_pop     = (enable && !w_err) ? w_pop_raw : 2'b00;
  assign w_keep    = (w_next == SYNC) || (w_next == RUN_L0) || (w_next == RUN_L1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = SYNC;
      SYNC:    w_next = w_err ? ERR : ((w_cnt[0] != 2'd0 || w_push[0]) && (w_cnt[1] != 2'd0 || w_push[1])) ? RUN_L0 : SYNC;
      RUN_L0:  w_next = w_err ? ERR : w_pop_raw[0] ? RUN_L1 : RUN_L0;
      RUN_L1:  w_next = w_err ? ERR : w_pop_raw[1] ? RUN_L0 : RUN_L1;
      default: w_next = ERR;
    endcase
    if (!enable) w_next = IDLE;
  end
  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic [1:0]   r_cnt;
    logic [W-1:0] r_mem [2];
    assign w_cnt[l]  = r_cnt;
    assign w_head[l] = r_mem[0];
    always_ff @(posedge clk_2f or negedge reset_L) begin
      if (!reset_L) begin
        r_cnt    <= 2'd0;
        r_mem[0] <= '0;
        r_mem[1] <= '0;
      end else if (!w_keep) begin
        r_cnt <= 2'd0;
      end else begin
        r_cnt <= r_cnt + 2'(w_push[l]) - 2'(w_pop[l]);
        if (w_pop[l]) begin
          r_mem[0] <= (w_push[l] && r_cnt == 2'd1) ? w_lane[l] : r_mem[1];
          if (w_push[l]) r_mem[1] <= w_lane[l];
        end else if (w_push[l]) begin
          r_mem[r_cnt[0]] <= w_lane[l];
        end
      end
    end
  end
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      r_state    <= IDLE;
      r_stall    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_lane_sel <= 1'b0;
      r_word_cnt <= 16'd0;
    end else begin
      r_state    <= w_next;
      r_stall    <= (enable && w_run && !(|w_pop_raw) && !w_err) ? r_stall + SW'(1) : '0;
      r_valid    <= |w_pop;
      if (|w_pop) r_data <= w_pop[1] ? w_head[1] : w_head[0];
      r_word_cnt <= (w_next == IDLE) ? 16'd0 : r_word_cnt + 16'(|w_pop);
      r_lane_sel <= (w_next == RUN_L1) ? 1'b1 : (w_next == ERR) ? r_lane_sel : 1'b0;
    end
  end
  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign lane_sel  = r_lane_sel;
  assign error     = (r_state == ERR);
  assign state     = r_state;
  assign word_cnt  = r_word_cnt;
endmodule

// File: tb/tb_unstripe_ctrl.sv
// tb_unstripe_ctrl: directed stimulus with a queue scoreboard checked by an
// independent output monitor.
module tb_unstripe_ctrl;
  logic        clk_2f = 1'b0;
  logic        reset_L, enable, valid_0, valid_1;
  logic [31:0] lane_0, lane_1, data_out;
  logic        valid_out, lane_sel, error;
  logic [2:0]  state;
  logic [15:0] word_cnt;
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  unstripe_ctrl #(.STALL_MAX(15), .W(32)) dut (
    .clk_2f(clk_2f), .reset_L(reset_L), .enable(enable),
    .valid_0(valid_0), .valid_1(valid_1), .lane_0(lane_0), .lane_1(lane_1),
    .data_out(data_out), .valid_out(valid_out), .lane_sel(lane_sel),
    .error(error), .state(state), .word_cnt(word_cnt)
  );

  always #5 clk_2f = ~clk_2f;

  always @(negedge clk_2f) begin
    logic [31:0] e;
    if (reset_L && valid_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL data_out unexpected word got %h expected none", data_out);
      end else begin
        e = exp_q.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL data_out order got %h expected %h", data_out, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic v0, input logic v1, input logic [31:0] d0, input logic [31:0] d1);
    valid_0 = v0;
    valid_1 = v1;
    lane_0  = d0;
    lane_1  = d1;
    @(posedge clk_2f);
    #1;
    valid_0 = 1'b0;
    valid_1 = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    reset_L = 1'b0; enable = 1'b0; valid_0 = 1'b0; valid_1 = 1'b0; lane_0 = '0; lane_1 = '0;
    #2;
    chk("reset state", 32'(state), 32'd0);
    chk("reset data_out", data_out, 32'h0);
    chk("reset valid_out", 32'(valid_out), 32'd0);
    chk("reset lane_sel", 32'(lane_sel), 32'd0);
    chk("reset error", 32'(error), 32'd0);
    chk("reset word_cnt", 32'(word_cnt), 32'd0);
    #10 reset_L = 1'b1;
    idle(1);
    chk("idle hold without enable", 32'(state), 32'd0);

    // basic alternation and minimum latency
    enable = 1'b1;
    idle(1);
    chk("sync entry", 32'(state), 32'd1);
    exp_q.push_back(32'hA0); exp_q.push_back(32'hB0);
    step(1'b1, 1'b1, 32'hA0, 32'hB0);
    chk("run_l0 after sync", 32'(state), 32'd2);
    chk("no pop in sync", 32'(valid_out), 32'd0);
    exp_q.push_back(32'hA1); exp_q.push_back(32'hB1);
    step(1'b1, 1'b1, 32'hA1, 32'hB1);
    chk("first word latency", data_out, 32'hA0);
    chk("lane_sel run_l1", 32'(lane_sel), 32'd1);
    idle(3);
    chk("word_cnt after 4", 32'(word_cnt), 32'd4);

    // stall timeout
    idle(14);
    chk("stall still run", 32'(state), 32'd2);
    chk("stall valid_out", 32'(valid_out), 32'd0);
    idle(1);
    chk("stall timeout err", 32'(state), 32'd4);
    chk("stall error flag", 32'(error), 32'd1);
    chk("err word_cnt hold", 32'(word_cnt), 32'd4);
    enable = 1'b0;
    idle(1);
    chk("disable to idle", 32'(state), 32'd0);
    chk("disable clears error", 32'(error), 32'd0);
    chk("disable clears word_cnt", 32'(word_cnt), 32'd0);

    // overflow on lane 0 while waiting on lane 1
    enable = 1'b1;
    idle(1);
    exp_q.push_back(32'hC0); exp_q.push_back(32'hD0);
    step(1'b1, 1'b1, 32'hC0, 32'hD0);
    idle(1);
    exp_q.push_back(32'hC1);
    step(1'b1, 1'b0, 32'hC1, 32'h0);
    idle(1);
    step(1'b1, 1'b0, 32'hE0, 32'h0);
    step(1'b1, 1'b0, 32'hE1, 32'h0);
    chk("full fifo no err", 32'(state), 32'd3);
    step(1'b1, 1'b0, 32'hE2, 32'h0);
    chk("overflow err", 32'(state), 32'd4);
    chk("overflow error flag", 32'(error), 32'd1);
    chk("err lane_sel hold", 32'(lane_sel), 32'd1);
    chk("err valid_out", 32'(valid_out), 32'd0);
    step(1'b1, 1'b1, 32'hEE, 32'hEE);
    chk("err persists", 32'(state), 32'd4);
    enable = 1'b0;
    idle(1);
    chk("err to idle lane_sel", 32'(lane_sel), 32'd0);

    // push and pop on a full FIFO
    enable = 1'b1;
    idle(1);
    exp_q.push_back(32'hF0); exp_q.push_back(32'h60);
    step(1'b1, 1'b1, 32'hF0, 32'h60);
    exp_q.push_back(32'hF1);
    step(1'b1, 1'b0, 32'hF1, 32'h0);
    step(1'b1, 1'b0, 32'hF2, 32'h0);
    exp_q.push_back(32'h61);
    step(1'b1, 1'b1, 32'hF3, 32'h61);
    chk("push pop full no err", 32'(state), 32'd3);
    exp_q.push_back(32'hF2); exp_q.push_back(32'h62); exp_q.push_back(32'hF3);
    step(1'b0, 1'b1, 32'h0, 32'h62);
    idle(4);
    chk("push pop final state", 32'(state), 32'd3);
    chk("push pop word_cnt", 32'(word_cnt), 32'd7);

    // enable dropped with buffered words
    step(1'b1, 1'b1, 32'h70, 32'h80);
    enable = 1'b0;
    idle(1);
    chk("drop state", 32'(state), 32'd0);
    chk("drop word_cnt", 32'(word_cnt), 32'd0);
    enable = 1'b1;
    idle(2);
    chk("resync needed", 32'(state), 32'd1);
    chk("flushed no output", 32'(valid_out), 32'd0);
    exp_q.push_back(32'h90); exp_q.push_back(32'h91);
    step(1'b1, 1'b1, 32'h90, 32'h91);
    idle(1);
    chk("resumed word", data_out, 32'h90);

    // asynchronous reset mid-run
    #2 reset_L = 1'b0;
    #1;
    chk("async reset state", 32'(state), 32'd0);
    chk("async reset valid", 32'(valid_out), 32'd0);
    chk("async reset data", data_out, 32'h0);
    chk("async reset word_cnt", 32'(word_cnt), 32'd0);
    exp_q.delete();
    #3 reset_L = 1'b1;
    @(posedge clk_2f);
    #1;
    chk("post reset sync", 32'(state), 32'd1);
    idle(1);
    chk("post reset no output", 32'(valid_out), 32'd0);
    exp_q.push_back(32'h55); exp_q.push_back(32'h66);
    step(1'b1, 1'b1, 32'h55, 32'h66);
    idle(3);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
